// File: rtl/life_game_ctrl.sv
// life_game_ctrl: control sequencer for the 7x7 Game-of-Life engine.
// Decodes the user pads into a STOP/PRGM/PLAY/PAUSE game FSM, strobes one
// grid cell per button press while programming, and paces generation steps
// to the next-state engine through a req/done handshake.
module life_game_ctrl #(
    parameter int N_CELLS    = 49,
    parameter int ADDR_W     = 6,
    parameter int GEN_PERIOD = 4,
    parameter int GEN_W      = 8
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_stop,
    input  logic              in_prgm,
    input  logic              in_pp,
    input  logic              in_btn0,
    input  logic              in_btn1,
    input  logic              in_step_done,
    output logic [1:0]        out_game_state,
    output logic              out_cell_we,
    output logic [ADDR_W-1:0] out_cell_addr,
    output logic              out_cell_data,
    output logic              out_clear,
    output logic              out_step_req,
    output logic              out_prgm_done,
    output logic [GEN_W-1:0]  out_gen_count
);

    localparam int TICK_W = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_PRGM  = 2'b01,
        ST_PLAY  = 2'b10,
        ST_PAUSE = 2'b11
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cursor;
    logic [TICK_W-1:0]   tick;
    logic                pp_q;
    logic                stop_q;

    logic                pp_edge;
    logic                btn_one;
    logic                cursor_last;
    logic                tick_last;

    assign pp_edge     = in_pp & ~pp_q;
    assign btn_one     = in_btn0 ^ in_btn1;
    assign cursor_last = (cursor == ADDR_W'(N_CELLS - 1));
    assign tick_last   = (tick == TICK_W'(GEN_PERIOD - 1));

    // The state register is the game-state output; it is already registered.
    assign out_game_state = state;

    // Game FSM, programming cursor and step scheduler, all in one register stage.
    // NOTE: every state register here uses <= so all updates see pre-edge values.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state         <= ST_STOP;
            cursor        <= '0;
            tick          <= '0;
            pp_q          <= 1'b0;
            stop_q        <= 1'b0;
            out_cell_we   <= 1'b0;
            out_cell_addr <= '0;
            out_cell_data <= 1'b0;
            out_clear     <= 1'b0;
            out_step_req  <= 1'b0;
            out_prgm_done <= 1'b0;
            out_gen_count <= '0;
        end else begin
            pp_q          <= in_pp;
            stop_q        <= in_stop;
            out_cell_we   <= 1'b0;
            out_prgm_done <= 1'b0;
            out_clear     <= 1'b0;

            if (in_stop) begin
                // Stop beats everything, including a coincident step_done.
                state         <= ST_STOP;
                cursor        <= '0;
                tick          <= '0;
                out_cell_addr <= '0;
                out_step_req  <= 1'b0;
                out_gen_count <= '0;
                out_clear     <= ~stop_q;
            end else begin
                unique case (state)
                    ST_STOP: begin
                        if (in_prgm) begin
                            state         <= ST_PRGM;
                            cursor        <= '0;
                            out_cell_addr <= '0;
                        end
                    end

                    ST_PRGM: begin
                        if (pp_edge) begin
                            state <= ST_PLAY;
                            tick  <= '0;
                        end else if (btn_one) begin
                            // Address shows the cell being written during the strobe.
                            out_cell_we   <= 1'b1;
                            out_cell_addr <= cursor;
                            out_cell_data <= in_btn1;
                            if (cursor_last) begin
                                cursor        <= '0;
                                out_prgm_done <= 1'b1;
                            end else begin
                                cursor <= cursor + ADDR_W'(1);
                            end
                        end else begin
                            out_cell_addr <= cursor;
                        end
                    end

                    ST_PLAY, ST_PAUSE: begin
                        if (pp_edge) begin
                            state <= (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
                        end
                        // An outstanding request always completes, paused or not.
                        if (out_step_req) begin
                            if (in_step_done) begin
                                out_step_req  <= 1'b0;
                                out_gen_count <= out_gen_count + GEN_W'(1);
                            end
                        end else if (state == ST_PLAY && !pp_edge) begin
                            if (tick_last) begin
                                out_step_req <= 1'b1;
                                tick         <= '0;
                            end else begin
                                tick <= tick + TICK_W'(1);
                            end
                        end
                    end

                    default: state <= ST_STOP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_game_ctrl.sv
// tb_life_game_ctrl: directed self-checking bench for life_game_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_life_game_ctrl;

    localparam int N_CELLS    = 49;
    localparam int ADDR_W     = 6;
    localparam int GEN_PERIOD = 4;
    localparam int GEN_W      = 8;

    logic              in_clk = 1'b0;
    logic              in_rst_n;
    logic              in_stop;
    logic              in_prgm;
    logic              in_pp;
    logic              in_btn0;
    logic              in_btn1;
    logic              in_step_done;
    logic [1:0]        out_game_state;
    logic              out_cell_we;
    logic [ADDR_W-1:0] out_cell_addr;
    logic              out_cell_data;
    logic              out_clear;
    logic              out_step_req;
    logic              out_prgm_done;
    logic [GEN_W-1:0]  out_gen_count;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int mark;
    int waited;

    life_game_ctrl #(
        .N_CELLS   (N_CELLS),
        .ADDR_W    (ADDR_W),
        .GEN_PERIOD(GEN_PERIOD),
        .GEN_W     (GEN_W)
    ) dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .in_stop       (in_stop),
        .in_prgm       (in_prgm),
        .in_pp         (in_pp),
        .in_btn0       (in_btn0),
        .in_btn1       (in_btn1),
        .in_step_done  (in_step_done),
        .out_game_state(out_game_state),
        .out_cell_we   (out_cell_we),
        .out_cell_addr (out_cell_addr),
        .out_cell_data (out_cell_data),
        .out_clear     (out_clear),
        .out_step_req  (out_step_req),
        .out_prgm_done (out_prgm_done),
        .out_gen_count (out_gen_count)
    );

    always #5 in_clk = ~in_clk;

    task automatic step();
        @(posedge in_clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance until a step request is seen, bounded by budget cycles.
    task automatic wait_req(input int budget, output int n);
        n = 0;
        while (out_step_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("req_arrives", 32'(out_step_req), 32'd1);
    endtask

    // Engine model: done is sampled on the third edge after req appeared.
    task automatic answer_done();
        step();
        step();
        in_step_done = 1'b1;
        step();
        in_step_done = 1'b0;
    endtask

    initial begin
        in_rst_n     = 1'b0;
        in_stop      = 1'b0;
        in_prgm      = 1'b0;
        in_pp        = 1'b0;
        in_btn0      = 1'b0;
        in_btn1      = 1'b0;
        in_step_done = 1'b0;
        #1;
        check("rst_state", 32'(out_game_state), 32'd0);
        check("rst_req",   32'(out_step_req),   32'd0);
        check("rst_gen",   32'(out_gen_count),  32'd0);
        check("rst_clear", 32'(out_clear),      32'd0);
        #11;
        in_rst_n = 1'b1;

        // 1: stop held two cycles gives a single clear pulse.
        in_stop = 1'b1;
        step();
        check("stop_state",   32'(out_game_state), 32'd0);
        check("stop_clear1",  32'(out_clear),      32'd1);
        step();
        check("stop_clear2",  32'(out_clear),      32'd0);
        in_stop = 1'b0;
        step();
        check("stop_clear3",  32'(out_clear),      32'd0);
        check("stop_gen",     32'(out_gen_count),  32'd0);

        // 2: enter PRGM and write 1,0,0,0,0,0,1 at addresses 0..6.
        in_prgm = 1'b1;
        step();
        check("prgm_state", 32'(out_game_state), 32'd1);
        step();
        in_prgm = 1'b0;
        in_btn1 = 1'b1;
        step();
        check("wr0_we",   32'(out_cell_we),   32'd1);
        check("wr0_addr", 32'(out_cell_addr), 32'd0);
        check("wr0_data", 32'(out_cell_data), 32'd1);
        in_btn1 = 1'b0;
        in_btn0 = 1'b1;
        for (int a = 1; a <= 5; a++) begin
            step();
            check("wr_we",   32'(out_cell_we),   32'd1);
            check("wr_addr", 32'(out_cell_addr), 32'(a));
            check("wr_data", 32'(out_cell_data), 32'd0);
        end
        in_btn0 = 1'b0;
        in_btn1 = 1'b1;
        step();
        check("wr6_addr", 32'(out_cell_addr), 32'd6);
        check("wr6_data", 32'(out_cell_data), 32'd1);
        in_btn1 = 1'b0;
        step();
        check("idle_we",     32'(out_cell_we),    32'd0);
        check("cursor7",     32'(out_cell_addr),  32'd7);
        check("prgm_state2", 32'(out_game_state), 32'd1);

        // 3: both buttons is a no-op, then fill up to the last cell.
        in_btn0 = 1'b1;
        in_btn1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("both_we",   32'(out_cell_we),   32'd0);
            check("both_addr", 32'(out_cell_addr), 32'd7);
        end
        in_btn0 = 1'b0;
        for (int a = 7; a < N_CELLS; a++) begin
            step();
            check("fill_we",   32'(out_cell_we),   32'd1);
            check("fill_addr", 32'(out_cell_addr), 32'(a));
            check("fill_done", 32'(out_prgm_done), (a == N_CELLS - 1) ? 32'd1 : 32'd0);
        end
        in_btn1 = 1'b0;
        step();
        check("wrap_addr", 32'(out_cell_addr), 32'd0);
        check("wrap_done", 32'(out_prgm_done), 32'd0);

        // 4: held pp gives one toggle into PLAY; requests every GEN_PERIOD+3 cycles.
        in_pp = 1'b1;
        step();
        mark = cyc;
        check("play_state", 32'(out_game_state), 32'd2);
        step();
        step();
        check("play_held", 32'(out_game_state), 32'd2);
        in_pp = 1'b0;
        wait_req(20, waited);
        check("first_req_lat", 32'(cyc - mark), 32'(GEN_PERIOD));
        check("play_clear", 32'(out_clear), 32'd0);
        for (int g = 1; g <= 3; g++) begin
            mark = cyc;
            answer_done();
            check("req_drop", 32'(out_step_req),  32'd0);
            check("gen_cnt",  32'(out_gen_count), 32'(g));
            wait_req(30, waited);
            check("req_period", 32'(cyc - mark), 32'(GEN_PERIOD + 3));
        end

        // 5: pause with a request outstanding, then resume.
        in_pp = 1'b1;
        step();
        in_pp = 1'b0;
        check("pause_state", 32'(out_game_state), 32'd3);
        check("pause_req",   32'(out_step_req),   32'd1);
        step();
        check("pause_req2",  32'(out_step_req),   32'd1);
        in_step_done = 1'b1;
        step();
        in_step_done = 1'b0;
        check("pause_drop", 32'(out_step_req),  32'd0);
        check("pause_gen",  32'(out_gen_count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            step();
            check("pause_noreq", 32'(out_step_req), 32'd0);
        end
        check("pause_hold", 32'(out_game_state), 32'd3);
        in_step_done = 1'b1;
        step();
        in_step_done = 1'b0;
        check("stray_done", 32'(out_gen_count), 32'd4);
        in_pp = 1'b1;
        step();
        in_pp = 1'b0;
        mark = cyc;
        check("resume_state", 32'(out_game_state), 32'd2);
        wait_req(20, waited);
        check("resume_lat", 32'(cyc - mark), 32'(GEN_PERIOD));

        // 6: stop (with a coincident done) during an outstanding request.
        in_stop      = 1'b1;
        in_step_done = 1'b1;
        step();
        in_step_done = 1'b0;
        check("s6_state", 32'(out_game_state), 32'd0);
        check("s6_req",   32'(out_step_req),   32'd0);
        check("s6_clear", 32'(out_clear),      32'd1);
        check("s6_gen",   32'(out_gen_count),  32'd0);
        step();
        check("s6_clear2", 32'(out_clear), 32'd0);
        in_stop = 1'b0;
        in_pp   = 1'b1;
        step();
        in_pp = 1'b0;
        check("stop_ignores_pp", 32'(out_game_state), 32'd0);

        // Back to PLAY, complete one generation, then async reset mid-cycle.
        in_prgm = 1'b1;
        step();
        in_prgm = 1'b0;
        in_pp   = 1'b1;
        step();
        in_pp = 1'b0;
        check("s6_play", 32'(out_game_state), 32'd2);
        wait_req(20, waited);
        answer_done();
        check("s6_gen1", 32'(out_gen_count), 32'd1);
        wait_req(30, waited);
        #2;
        in_rst_n = 1'b0;
        #1;
        check("arst_state", 32'(out_game_state), 32'd0);
        check("arst_req",   32'(out_step_req),   32'd0);
        check("arst_gen",   32'(out_gen_count),  32'd0);
        check("arst_addr",  32'(out_cell_addr),  32'd0);
        check("arst_clear", 32'(out_clear),      32'd0);
        step();
        step();
        #3;
        in_rst_n = 1'b1;
        step();
        check("post_rst_clear", 32'(out_clear),      32'd0);
        check("post_rst_state", 32'(out_game_state), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
